// File: rtl/arm_rf_pkg.sv
// rtl/arm_rf_pkg.sv - shared constants, state enum and W-form helper for arm_regfile_mp
package arm_rf_pkg;
  localparam int RF_DATA_W = 64;
  localparam int RF_ADDR_W = 5;
  localparam int RF_MAX_W  = 64;
  localparam int RF_XZR    = (1 << RF_ADDR_W) - 1;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // W-form writes keep the low word and always zero-extend
  function automatic logic [RF_MAX_W-1:0] rf_w_form(input logic [RF_MAX_W-1:0] d,
                                                     input logic w32);
    return w32 ? {32'h0, d[31:0]} : d;
  endfunction
endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port: XZR check, write bypass, storage mux, busy lookup
module rf_read_port
  import arm_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                  run_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0]     wr_val_i,
  input  logic [DATA_W-1:0]     mem_i [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]  busy_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  rd_busy_o
);
  localparam logic [ADDR_W-1:0] XZR = ADDR_W'((2**ADDR_W) - 1);

  logic is_xzr;
  assign is_xzr = (ZERO_REG != 0) && (rd_addr_i == XZR);

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = 1'b0;
    if (run_i) begin
      // busy reflects registered state only; a same-cycle write is covered by the bypass
      rd_busy_o = busy_i[rd_addr_i];
      if (is_xzr) begin
        rd_data_o = '0;
      end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_o = wr_val_i;
      end else begin
        rd_data_o = mem_i[rd_addr_i];
      end
    end
  end
endmodule

// File: rtl/arm_regfile_mp.sv
// rtl/arm_regfile_mp.sv - multi-read-port integer register file with XZR, W-form writes, bypass and scoreboard
module arm_regfile_mp
  import arm_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_w32,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr,
  output logic                       ready
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               run;
  logic               wr_xzr, alloc_xzr;
  logic [DATA_W-1:0]  wr_val;

  assign wr_xzr    = (ZERO_REG != 0) && (wr_addr == LAST);
  assign alloc_xzr = (ZERO_REG != 0) && (alloc_addr == LAST);
  assign wr_val    = DATA_W'(rf_w_form(RF_MAX_W'(wr_data), wr_w32));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) state_d = RF_RUN;
      end
      RF_RUN:  state_d = RF_RUN;
      default: state_d = RF_INIT;
    endcase
  end

  always_comb begin
    run   = (state_q == RF_RUN);
    ready = run;
  end

  // alloc is applied after the write clear so a same-index alloc wins
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (wr_en) busy_d[wr_addr] = 1'b0;
      if (alloc_en && !alloc_xzr) busy_d[alloc_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[LAST] = 1'b0;
  end

  // storage has no reset; the clear engine rewrites every entry after each reset
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en && !wr_xzr) begin
      mem_q[wr_addr] <= wr_val;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .run_i     (run),
      .rd_addr_i (rd_addr[p*ADDR_W +: ADDR_W]),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_val_i  (wr_val),
      .mem_i     (mem_q),
      .busy_i    (busy_q),
      .rd_data_o (rd_data[p*DATA_W +: DATA_W]),
      .rd_busy_o (rd_busy[p])
    );
  end
endmodule

// File: doc/arm_regfile_mp.md
# arm_regfile_mp

Parametrised successor to the ARMv8 integer register bank. Provides NUM_RD combinational read ports and one synchronous write port. Adds the hardwired zero register XZR, 32-bit W-register writes, same-cycle write-to-read bypass, and a pending-write scoreboard. A sequential clear engine zeroes every entry after reset. It sits between decode/issue (reads, busy checks) and writeback (writes) in the CPU datapath.

## Interface
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 the highest index (31) reads 0 and ignores writes and allocs
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; asynchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  packed read indices; port p is bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational
- rd_busy  out  NUM_RD  per-port scoreboard busy bit for rd_addr
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- wr_w32  in  1  W-form write: stores {zeros, wr_data[31:0]}
- alloc_en  in  1  mark alloc_addr as having a pending producer
- alloc_addr  in  ADDR_W  index to mark busy
- ready  out  1  high once the clear sequence completes

## Operation
- FSM states: INIT and RUN. rst forces INIT, clear counter = 0, and all busy bits = 0.
- INIT: each cycle writes 0 to entry[counter], then increments the counter. After entry DEPTH-1 is cleared, the next state is RUN.
- INIT ignores wr_en and alloc_en. ready = 0. rd_data = 0 and rd_busy = 0 on all ports.
- RUN: ready = 1.
  - When wr_en is set and wr_addr is not XZR, entry[wr_addr] <= wr_w32 ? zero-extended low 32 bits : wr_data.
  - A W-form write always zero-extends and never sign-extends.
- Read port p in RUN:
  - If rd_addr_p is XZR (ZERO_REG=1), data = 0.
  - Otherwise, if wr_en and wr_addr == rd_addr_p, data = the value being written this cycle, after W-form masking (bypass).
  - Otherwise, data = entry[rd_addr_p].
- Scoreboard in RUN:
  - alloc_en sets busy[alloc_addr].
  - wr_en clears busy[wr_addr].
  - If alloc and write hit the same index in one cycle, the alloc wins and busy stays 1, because a new producer exists.
  - alloc or write to XZR has no effect; busy[XZR] is always 0.
- rd_busy_p = busy[rd_addr_p], reflecting registered state only. A write in the same cycle does not clear it combinationally, because the bypass supplies the data instead.
- Multiple read ports may address the same index; each port is independent.

## Timing
- Reset values: ready = 0, rd_busy = 0, rd_data = 0, FSM = INIT, counter = 0.
- The clear sequence takes exactly DEPTH cycles from the first posedge after rst deasserts. ready rises on edge DEPTH (32 for defaults).
- Write latency is 1 cycle to storage and 0 cycles to read ports via the bypass.
- alloc takes effect on the next cycle: rd_busy asserts the cycle after alloc_en.
- rst asserted mid-INIT or mid-RUN takes effect immediately: busy bits clear and the clear sequence restarts. Register contents are undefined until the new sequence rewrites them.

## Structure
- Package arm_rf_pkg holds:
  - default DATA_W and ADDR_W
  - the XZR index constant (DEPTH-1)
  - the state enum {RF_INIT, RF_RUN}
  - a function for W-form masking
- Sub-module rf_read_port: one instance per read port, generated NUM_RD times. It contains the XZR check, the bypass compare, the storage mux and the busy lookup.
- The storage array, clear counter, FSM and busy vector live in the top module.

## Test plan
- Reset, then hold idle: ready is 0 for 32 cycles and 1 from cycle 32. Every index reads 0x0, and X31 reads 0.
- In RUN, write X5 = 0xDEAD_BEEF_1234_5678, then read on port 0 in the same cycle: the bypass returns the value. The next cycle, storage returns the same value.
- W-form write X7 with wr_data = 0xFFFF_FFFF_8000_0001: X7 reads 0x0000_0000_8000_0001.
- Write 0x55 to X31: all ports reading X31 return 0. alloc X31 gives rd_busy = 0.
- Scoreboard:
  - alloc X3: rd_busy = 1 the next cycle.
  - write X3 alone: busy clears.
  - alloc X4 and write X4 in the same cycle: busy stays 1.
- Assert rst for 1 cycle mid-RUN while X9 is busy: rd_busy = 0 immediately and ready = 0. Writes issued during the re-clear are ignored. ready returns after 32 cycles.
